// File: rtl/subneg_pkg.sv
// Shared types and helpers for the SUBNEG/SUBLEQ one-instruction core.
package subneg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        FETCH_C,
        LOAD_A,
        LOAD_B,
        EXE,
        WRITE,
        COMMIT
    } core_state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_ADR,
        PH_LAT,
        PH_ACT,
        PH_END
    } bus_phase_t;

    localparam logic MODE_SUBNEG = 1'b0;
    localparam logic MODE_SUBLEQ = 1'b1;

    // Top word of the address space is the memory-mapped I/O port.
    function automatic logic [31:0] io_addr(input int unsigned dw);
        return (32'd1 << dw) - 32'd1;
    endfunction

endpackage

// File: rtl/subneg_cpu_core_mem_bus_seq.sv
// Sequences one SRAM read or write through the external address latch.
module mem_bus_seq
    import subneg_pkg::*;
#(
    parameter int DW   = 8,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic [DW-1:0] bus_oe,
    output logic          latch_le,
    output logic          mem_oe_n,
    output logic          mem_we_n
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    bus_phase_t    phase_r;
    logic [3:0]    cnt_r;
    logic          we_r;
    logic [DW-1:0] wdata_r;

    // Ack is the END phase; a new request may start in that same cycle so accesses abut.
    assign ack = (phase_r == PH_END);

    // Bus phase sequencer with registered strobes and the wait-state counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r  <= PH_IDLE;
            cnt_r    <= 4'd0;
            we_r     <= 1'b0;
            wdata_r  <= {DW{1'b0}};
            rdata    <= {DW{1'b0}};
            bus_out  <= {DW{1'b0}};
            bus_oe   <= {DW{1'b1}};
            latch_le <= 1'b0;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
        end else begin
            case (phase_r)
                PH_IDLE, PH_END: begin
                    bus_oe <= {DW{1'b1}};
                    if (req) begin
                        phase_r  <= PH_ADR;
                        bus_out  <= addr;
                        latch_le <= 1'b1;
                        we_r     <= we;
                        wdata_r  <= wdata;
                    end else begin
                        phase_r  <= PH_IDLE;
                    end
                end
                PH_ADR: begin
                    phase_r  <= PH_LAT;
                    latch_le <= 1'b0;
                    if (we_r) begin
                        bus_out <= wdata_r;
                    end
                end
                PH_LAT: begin
                    phase_r <= PH_ACT;
                    cnt_r   <= WAIT_CNT;
                    if (we_r) begin
                        mem_we_n <= 1'b0;
                    end else begin
                        bus_oe   <= {DW{1'b0}};
                        mem_oe_n <= 1'b0;
                    end
                end
                PH_ACT: begin
                    if (cnt_r == 4'd0) begin
                        phase_r  <= PH_END;
                        mem_oe_n <= 1'b1;
                        mem_we_n <= 1'b1;
                        if (!we_r) begin
                            rdata <= bus_in;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    phase_r  <= PH_IDLE;
                    latch_le <= 1'b0;
                    mem_oe_n <= 1'b1;
                    mem_we_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/subneg_cpu_core.sv
// One-instruction (SUBNEG/SUBLEQ) core: fetch A,B,C, load operands, subtract, write back, branch.
module subneg_cpu_core
    import subneg_pkg::*;
#(
    parameter int DW        = 8,
    parameter int WAIT      = 1,
    parameter bit HALT_SELF = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          mode,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic [DW-1:0] bus_oe,
    output logic          latch_le,
    output logic          mem_oe_n,
    output logic          mem_we_n,
    input  logic [DW-1:0] io_in,
    output logic [DW-1:0] io_out,
    output logic          io_stb,
    output logic          halted,
    output logic [DW-1:0] pc
);

    localparam logic [DW-1:0] IO_ADDR = DW'(io_addr(DW));
    localparam logic [DW-1:0] ONE     = DW'(1);
    localparam logic [DW-1:0] TWO     = DW'(2);
    localparam logic [DW-1:0] THREE   = DW'(3);

    core_state_t   state_r, state_nxt_s;
    logic [DW-1:0] addr_a_r, addr_b_r, addr_c_r, val_a_r, val_b_r;
    logic          mode_r;
    logic          seq_req_s, seq_we_s, seq_ack_s;
    logic [DW-1:0] seq_rdata_s, cur_addr_s, nxt_addr_s, rd_val_s, result_s, pc_next_s;
    logic          io_rd_s, step_done_s, taken_s, halt_s;

    function automatic logic [DW-1:0] state_addr(input core_state_t st, input logic [DW-1:0] pc_v,
                                                  input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (st)
            FETCH_A: return pc_v;
            FETCH_B: return pc_v + ONE;
            FETCH_C: return pc_v + TWO;
            LOAD_A:  return a;
            LOAD_B:  return b;
            WRITE:   return b;
            default: return pc_v;
        endcase
    endfunction

    function automatic logic is_access(input core_state_t st);
        case (st)
            FETCH_A, FETCH_B, FETCH_C, LOAD_A, LOAD_B, WRITE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Next-state, datapath and bus-request decode; a request is issued on entry to an access state.
    always_comb begin
        cur_addr_s  = state_addr(state_r, pc, addr_a_r, addr_b_r);
        io_rd_s     = (cur_addr_s == IO_ADDR);
        rd_val_s    = io_rd_s ? io_in : seq_rdata_s;
        step_done_s = io_rd_s | seq_ack_s;
        result_s    = val_b_r - val_a_r;
        taken_s     = (mode_r == MODE_SUBLEQ) ? (val_a_r >= val_b_r) : (val_a_r > val_b_r);
        halt_s      = HALT_SELF && taken_s && (addr_c_r == pc);
        pc_next_s   = halt_s ? pc : (taken_s ? addr_c_r : pc + THREE);
        state_nxt_s = state_r;
        case (state_r)
            IDLE, COMMIT: begin
                if (ena && !halted) begin
                    state_nxt_s = FETCH_A;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH_A: if (step_done_s) state_nxt_s = FETCH_B; else state_nxt_s = FETCH_A;
            FETCH_B: if (step_done_s) state_nxt_s = FETCH_C; else state_nxt_s = FETCH_B;
            FETCH_C: if (step_done_s) state_nxt_s = LOAD_A;  else state_nxt_s = FETCH_C;
            LOAD_A:  if (step_done_s) state_nxt_s = LOAD_B;  else state_nxt_s = LOAD_A;
            LOAD_B:  if (step_done_s) state_nxt_s = EXE;     else state_nxt_s = LOAD_B;
            EXE: begin
                if (addr_b_r == IO_ADDR) begin
                    state_nxt_s = COMMIT;
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            WRITE:   if (seq_ack_s) state_nxt_s = COMMIT; else state_nxt_s = WRITE;
            default: state_nxt_s = IDLE;
        endcase
        nxt_addr_s = state_addr(state_nxt_s, pc, addr_a_r, addr_b_r);
        seq_req_s  = (state_nxt_s != state_r) && is_access(state_nxt_s) && (nxt_addr_s != IO_ADDR);
        seq_we_s   = (state_nxt_s == WRITE);
    end

    // Core FSM: operand capture, I/O write, commit and halt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            mode_r   <= MODE_SUBNEG;
            addr_a_r <= {DW{1'b0}};
            addr_b_r <= {DW{1'b0}};
            addr_c_r <= {DW{1'b0}};
            val_a_r  <= {DW{1'b0}};
            val_b_r  <= {DW{1'b0}};
            pc       <= {DW{1'b0}};
            io_out   <= {DW{1'b0}};
            io_stb   <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            io_stb  <= 1'b0;
            case (state_r)
                IDLE, COMMIT: if (state_nxt_s == FETCH_A) mode_r <= mode;
                FETCH_A:      if (step_done_s) addr_a_r <= rd_val_s;
                FETCH_B:      if (step_done_s) addr_b_r <= rd_val_s;
                FETCH_C:      if (step_done_s) addr_c_r <= rd_val_s;
                LOAD_A:       if (step_done_s) val_a_r <= rd_val_s;
                LOAD_B:       if (step_done_s) val_b_r <= rd_val_s;
                EXE: begin
                    if (addr_b_r == IO_ADDR) begin
                        io_out <= result_s;
                        io_stb <= 1'b1;
                        pc     <= pc_next_s;
                        if (halt_s) halted <= 1'b1;
                    end
                end
                WRITE: begin
                    if (seq_ack_s) begin
                        pc <= pc_next_s;
                        if (halt_s) halted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_bus_seq #(
        .DW   (DW),
        .WAIT (WAIT)
    ) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (seq_req_s),
        .we       (seq_we_s),
        .addr     (nxt_addr_s),
        .wdata    (result_s),
        .ack      (seq_ack_s),
        .rdata    (seq_rdata_s),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .latch_le (latch_le),
        .mem_oe_n (mem_oe_n),
        .mem_we_n (mem_we_n)
    );

endmodule
